// File: rtl/dyt_sram_arb.sv
// Two-port (instruction + data) arbiter in front of a single-port SRAM with a
// registered read output of configurable latency. One transaction is in flight
// at a time. Contention is resolved by alternating grants.
//
// Ports:
//   clk, n_rst            clock, async active-low reset
//   i_req/i_addr          instruction-port read request (level, held until i_done)
//   i_rdata/i_done        instruction-port read data (registered) and done pulse
//   d_req/d_we/d_addr/
//   d_wdata               data-port request; d_we != 0 means write
//   d_rdata/d_done        data-port read data (registered) and done pulse
//   sram_address/
//   sram_w_data/sram_wen/
//   sram_ren/sram_r_data  SRAM-side interface
//   busy                  high whenever the FSM is not idle
module dyt_sram_arb #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned WE_W         = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic [WE_W-1:0]   d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [DATA_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_w_data,
  output logic [WE_W-1:0]   sram_wen,
  output logic              sram_ren,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             sel_port;
  logic             is_write;
  logic [CNT_W-1:0] wait_cnt;

  logic grant_valid_c;
  logic grant_port_c;

  // Arbitration: lone requester wins; on contention the port not granted last wins.
  assign grant_valid_c = i_req | d_req;

  always_comb begin
    grant_port_c = PORT_I;
    if (i_req && d_req) begin
      grant_port_c = ~last_grant;
    end else if (d_req) begin
      grant_port_c = PORT_D;
    end
  end

  // FSM with all SRAM-side and port-side outputs registered. The SRAM address
  // and write data registers double as the latched request copies, so request
  // inputs are free to change once the grant is taken.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      last_grant   <= PORT_I;
      sel_port     <= PORT_I;
      is_write     <= 1'b0;
      wait_cnt     <= '0;
      sram_address <= '0;
      sram_w_data  <= '0;
      sram_wen     <= '0;
      sram_ren     <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid_c) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            sel_port   <= grant_port_c;
            last_grant <= grant_port_c;
            if (grant_port_c == PORT_D) begin
              sram_address <= d_addr;
              if (d_we != '0) begin
                is_write    <= 1'b1;
                sram_wen    <= d_we;
                sram_w_data <= d_wdata;
              end else begin
                is_write <= 1'b0;
                sram_ren <= 1'b1;
              end
            end else begin
              // Instruction port is read-only.
              sram_address <= i_addr;
              is_write     <= 1'b0;
              sram_ren     <= 1'b1;
            end
          end
        end

        ACCESS: begin
          if (is_write) begin
            state        <= DONE;
            sram_wen     <= '0;
            sram_w_data  <= '0;
            sram_address <= '0;
            if (sel_port == PORT_D) begin
              d_done <= 1'b1;
            end else begin
              i_done <= 1'b1;
            end
          end else begin
            state    <= WAIT;
            wait_cnt <= CNT_W'(READ_LATENCY - 1);
          end
        end

        WAIT: begin
          // Address and ren stay asserted; data is captured at the end of the last cycle.
          if (wait_cnt == '0) begin
            state        <= DONE;
            sram_ren     <= 1'b0;
            sram_address <= '0;
            if (sel_port == PORT_D) begin
              d_rdata <= sram_r_data;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= sram_r_data;
              i_done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        DONE: begin
          // Requests are ignored here; the requester drops req at this edge.
          state  <= IDLE;
          busy   <= 1'b0;
          i_done <= 1'b0;
          d_done <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dyt_sram_arb.sv
// Bench for dyt_sram_arb: four instances (READ_LATENCY 1..4) over a shared
// behavioural SRAM; instance 1 (READ_LATENCY=2) carries the main tests.
module tb_dyt_sram_arb;

  logic        clk;
  logic        n_rst;
  logic        i_req        [4];
  logic [31:0] i_addr       [4];
  logic [31:0] i_rdata      [4];
  logic        i_done       [4];
  logic        d_req        [4];
  logic [3:0]  d_we         [4];
  logic [31:0] d_addr       [4];
  logic [31:0] d_wdata      [4];
  logic [31:0] d_rdata      [4];
  logic        d_done       [4];
  logic [31:0] sram_address [4];
  logic [31:0] sram_w_data  [4];
  logic [3:0]  sram_wen     [4];
  logic        sram_ren     [4];
  logic [31:0] sram_r_data  [4];
  logic        busy         [4];

  logic [31:0] mem [64];
  bit          mem_init;

  int checks;
  int failures;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dyt_sram_arb #(
      .READ_LATENCY(g + 1),
      .DATA_W(32),
      .WE_W(4)
    ) u_dut (
      .clk(clk),
      .n_rst(n_rst),
      .i_req(i_req[g]),
      .i_addr(i_addr[g]),
      .i_rdata(i_rdata[g]),
      .i_done(i_done[g]),
      .d_req(d_req[g]),
      .d_we(d_we[g]),
      .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]),
      .d_done(d_done[g]),
      .sram_address(sram_address[g]),
      .sram_w_data(sram_w_data[g]),
      .sram_wen(sram_wen[g]),
      .sram_ren(sram_ren[g]),
      .sram_r_data(sram_r_data[g]),
      .busy(busy[g])
    );
    assign sram_r_data[g] = mem[sram_address[g][5:0]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: byte-enabled write on the edge ending the ACCESS cycle.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem_init <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        for (int b = 0; b < 4; b++)
          if (sram_wen[k][b])
            mem[sram_address[k][5:0]][b*8 +: 8] <= sram_w_data[k][b*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear(input int k);
    i_req[k]   = 1'b0;
    i_addr[k]  = 32'h0;
    d_req[k]   = 1'b0;
    d_we[k]    = 4'h0;
    d_addr[k]  = 32'h0;
    d_wdata[k] = 32'h0;
  endtask

  // Issue one request, measure cycles to done (-1 on timeout), drop req at the
  // edge ending the done cycle.
  task automatic txn(input int k, input bit port, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    @(posedge clk); #1;
    if (port) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (port ? d_done[k] : i_done[k]) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    clear(k);
  endtask

  typedef struct {
    bit          port;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int both;
    int ndone;
    logic [3:0] order;

    checks = 0;
    failures = 0;
    for (int k = 0; k < 4; k++) clear(k);
    n_rst = 1'b0;

    vecs[0] = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 2, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 4'h0, 32'h10, 32'h0,        4, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 4'h2, 32'h10, 32'h0000AB00, 2, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b1, 4'h0, 32'h10, 32'h0,        4, 32'hDEADBEEF, 32'hDEADABEF};
    vecs[4] = '{1'b1, 4'hC, 32'h20, 32'h12345678, 2, 32'hDEADBEEF, 32'hDEADABEF};
    vecs[5] = '{1'b0, 4'h0, 32'h20, 32'h0,        4, 32'h12340000, 32'hDEADABEF};
    vecs[6] = '{1'b1, 4'hF, 32'h24, 32'hCAFEF00D, 2, 32'h12340000, 32'hDEADABEF};
    vecs[7] = '{1'b1, 4'h0, 32'h24, 32'h0,        4, 32'h12340000, 32'hCAFEF00D};

    #12;
    chk("reset_busy", 32'(busy[1]), 32'h0);
    chk("reset_ren", 32'(sram_ren[1]), 32'h0);
    chk("reset_wen", 32'(sram_wen[1]), 32'h0);
    chk("reset_addr", sram_address[1], 32'h0);
    chk("reset_i_rdata", i_rdata[1], 32'h0);
    n_rst = 1'b1;

    // Cycle-accurate write then read on instance 1.
    @(posedge clk); #1;
    d_req[1] = 1'b1; d_we[1] = 4'hF; d_addr[1] = 32'h10; d_wdata[1] = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_c0_busy", 32'(busy[1]), 32'h0);
    chk("wr_c0_wen", 32'(sram_wen[1]), 32'h0);
    @(negedge clk);
    chk("wr_c1_wen", 32'(sram_wen[1]), 32'hF);
    chk("wr_c1_addr", sram_address[1], 32'h10);
    chk("wr_c1_wdata", sram_w_data[1], 32'hDEADBEEF);
    chk("wr_c1_done", 32'(d_done[1]), 32'h0);
    @(negedge clk);
    chk("wr_c2_done", 32'(d_done[1]), 32'h1);
    chk("wr_c2_wen", 32'(sram_wen[1]), 32'h0);
    chk("wr_c2_idone", 32'(i_done[1]), 32'h0);
    @(posedge clk); #1;
    clear(1);
    @(negedge clk);
    chk("wr_c3_done", 32'(d_done[1]), 32'h0);
    chk("wr_c3_busy", 32'(busy[1]), 32'h0);
    chk("wr_c3_addr", sram_address[1], 32'h0);

    @(posedge clk); #1;
    i_req[1] = 1'b1; i_addr[1] = 32'h10;
    @(negedge clk);
    chk("rd_c0_ren", 32'(sram_ren[1]), 32'h0);
    @(negedge clk);
    chk("rd_c1_ren", 32'(sram_ren[1]), 32'h1);
    chk("rd_c1_addr", sram_address[1], 32'h10);
    chk("rd_c1_wen", 32'(sram_wen[1]), 32'h0);
    @(posedge clk); #1;
    i_addr[1] = 32'h44;
    @(negedge clk);
    chk("rd_c2_ren", 32'(sram_ren[1]), 32'h1);
    chk("rd_c2_addr_held", sram_address[1], 32'h10);
    @(negedge clk);
    chk("rd_c3_ren", 32'(sram_ren[1]), 32'h1);
    chk("rd_c3_addr_held", sram_address[1], 32'h10);
    chk("rd_c3_done", 32'(i_done[1]), 32'h0);
    @(negedge clk);
    chk("rd_c4_done", 32'(i_done[1]), 32'h1);
    chk("rd_c4_ren", 32'(sram_ren[1]), 32'h0);
    chk("rd_c4_rdata", i_rdata[1], 32'hDEADBEEF);
    @(posedge clk); #1;
    clear(1);
    @(negedge clk);
    chk("rd_c5_done", 32'(i_done[1]), 32'h0);
    chk("rd_c5_rdata_hold", i_rdata[1], 32'hDEADBEEF);

    // Table of directed transactions on instance 1.
    for (int v = 0; v < 8; v++) begin
      txn(1, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat);
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_i_rdata", v), i_rdata[1], vecs[v].exp_i);
      chk($sformatf("vec%0d_d_rdata", v), d_rdata[1], vecs[v].exp_d);
    end

    // Contention from reset: both held, grants alternate d,i,d,i.
    @(posedge clk); #1;
    n_rst = 1'b0;
    d_req[1] = 1'b1; d_addr[1] = 32'h10;
    i_req[1] = 1'b1; i_addr[1] = 32'h20;
    #2;
    n_rst = 1'b1;
    both = 0; ndone = 0; order = 4'h0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (i_done[1] && d_done[1]) both++;
      if ((i_done[1] || d_done[1]) && ndone < 4) begin
        order[3 - ndone] = d_done[1];
        ndone++;
      end
    end
    chk("arb_both_done", 32'(both), 32'h0);
    chk("arb_ndone", 32'(ndone), 32'h4);
    chk("arb_order", 32'(order), 32'hA);
    chk("arb_d_rdata", d_rdata[1], 32'hDEADABEF);
    chk("arb_i_rdata", i_rdata[1], 32'h12340000);
    @(posedge clk); #1;
    clear(1);
    n_rst = 1'b0;
    #3;
    n_rst = 1'b1;

    // Reset during WAIT of a read aborts it with no done pulse.
    @(posedge clk); #1;
    i_req[1] = 1'b1; i_addr[1] = 32'h24;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    chk("rst_pre_ren", 32'(sram_ren[1]), 32'h1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_ren", 32'(sram_ren[1]), 32'h0);
    chk("rst_addr", sram_address[1], 32'h0);
    chk("rst_busy", 32'(busy[1]), 32'h0);
    chk("rst_i_rdata", i_rdata[1], 32'h0);
    chk("rst_d_rdata", d_rdata[1], 32'h0);
    clear(1);
    @(posedge clk); #3;
    n_rst = 1'b1;
    both = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (i_done[1] || d_done[1] || busy[1]) both++;
    end
    chk("rst_no_done", 32'(both), 32'h0);
    txn(1, 1'b0, 4'h0, 32'h24, 32'h0, lat);
    chk("rst_after_lat", 32'(lat), 32'h4);
    chk("rst_after_rdata", i_rdata[1], 32'hCAFEF00D);

    // Read latency sweep across instances.
    for (int k = 0; k < 4; k++) begin
      txn(k, 1'b0, 4'h0, 32'h10, 32'h0, lat);
      chk($sformatf("sweep_rl%0d_lat", k + 1), 32'(lat), 32'(k + 3));
      chk($sformatf("sweep_rl%0d_rdata", k + 1), i_rdata[k], 32'hDEADABEF);
      txn(k, 1'b1, 4'h1, 32'h30, 32'h000000AA, lat);
      chk($sformatf("sweep_rl%0d_wlat", k + 1), 32'(lat), 32'h2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
